// File: rtl/frame_draw_sequencer_if.sv
// Bundles the game-FSM handshake, the snake segment read port and the VGA pixel
// bus of frame_draw_sequencer. The sequencer is the slave; its environment is the master.
interface frame_draw_sequencer_if;
  logic       start;
  logic [7:0] apple_x;
  logic [6:0] apple_y;
  logic [7:0] snake_size;
  logic [6:0] seg_idx;
  logic [7:0] seg_x;
  logic [6:0] seg_y;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output start, apple_x, apple_y, snake_size, seg_x, seg_y,
    input  seg_idx, x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, apple_x, apple_y, snake_size, seg_x, seg_y,
    output seg_idx, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/frame_draw_sequencer.sv
// Redraws a full game frame (clear, walls, apple, snake) into the VGA framebuffer,
// one registered pixel per cycle, between a start pulse and a single-cycle done.
module frame_draw_sequencer #(
  parameter int         SCREEN_W = 160,
  parameter int         SCREEN_H = 120,
  parameter int         WALL_T   = 2,
  parameter int         MAX_LEN  = 128,
  parameter logic [2:0] C_BG     = 3'b000,
  parameter logic [2:0] C_WALL   = 3'b111,
  parameter logic [2:0] C_APPLE  = 3'b100,
  parameter logic [2:0] C_HEAD   = 3'b110,
  parameter logic [2:0] C_BODY   = 3'b010
) (
  input  logic                   clk,
  input  logic                   resetn,
  frame_draw_sequencer_if.slave  bus
);

  localparam logic [7:0] W8        = 8'(SCREEN_W);
  localparam logic [6:0] H7        = 7'(SCREEN_H);
  localparam logic [7:0] X_LAST    = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST    = 7'(SCREEN_H - 1);
  localparam logic [7:0] X_WALL_L  = 8'(WALL_T - 1);
  localparam logic [7:0] X_WALL_R  = 8'(SCREEN_W - WALL_T);
  localparam logic [6:0] Y_WALL_T  = 7'(WALL_T - 1);
  localparam logic [6:0] Y_WALL_B  = 7'(SCREEN_H - WALL_T);
  localparam logic [6:0] Y_V_FIRST = 7'(WALL_T);
  localparam logic [6:0] Y_V_LAST  = 7'(SCREEN_H - WALL_T - 1);
  localparam logic [7:0] MAX8      = 8'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, CLEAR, WALL_H, WALL_V, APPLE, SNAKE, FIN} state_t;

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [6:0] seg_idx_q, seg_idx_d;
  logic [7:0] apple_x_q, apple_x_d;
  logic [6:0] apple_y_q, apple_y_d;
  logic [7:0] len_q, len_d;
  logic [7:0] seg_cnt_q, seg_cnt_d;

  logic       apple_on;
  logic       seg_on;
  logic [7:0] seg_next;

  assign apple_on = (apple_x_q < W8) && (apple_y_q < H7);
  assign seg_on   = (bus.seg_x < W8) && (bus.seg_y < H7);
  assign seg_next = seg_cnt_q + 8'd2;

  // Outputs are registered with lookahead: state_q names the phase whose pixel is
  // on x/y/colour this cycle, and x_q/y_q double as the raster counters.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    seg_idx_d = seg_idx_q;
    apple_x_d = apple_x_q;
    apple_y_d = apple_y_q;
    len_d     = len_q;
    seg_cnt_d = seg_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = CLEAR;
          apple_x_d = bus.apple_x;
          apple_y_d = bus.apple_y;
          len_d     = (bus.snake_size > MAX8) ? MAX8 : bus.snake_size;
          x_d       = '0;
          y_d       = '0;
          colour_d  = C_BG;
          plot_d    = 1'b1;
          busy_d    = 1'b1;
        end
      end

      CLEAR: begin
        plot_d   = 1'b1;
        colour_d = C_BG;
        if (x_q != X_LAST) begin
          x_d = x_q + 8'd1;
        end else if (y_q != Y_LAST) begin
          x_d = '0;
          y_d = y_q + 7'd1;
        end else begin
          state_d  = WALL_H;
          x_d      = '0;
          y_d      = '0;
          colour_d = C_WALL;
        end
      end

      // Top rows then bottom rows: the row counter jumps over the playfield.
      WALL_H: begin
        plot_d   = 1'b1;
        colour_d = C_WALL;
        if (x_q != X_LAST) begin
          x_d = x_q + 8'd1;
        end else if (y_q == Y_LAST) begin
          state_d = WALL_V;
          x_d     = '0;
          y_d     = Y_V_FIRST;
        end else begin
          x_d = '0;
          y_d = (y_q == Y_WALL_T) ? Y_WALL_B : y_q + 7'd1;
        end
      end

      WALL_V: begin
        colour_d = C_WALL;
        plot_d   = 1'b1;
        if (x_q == X_WALL_L) begin
          x_d = X_WALL_R;
        end else if (x_q != X_LAST) begin
          x_d = x_q + 8'd1;
        end else if (y_q != Y_V_LAST) begin
          x_d = '0;
          y_d = y_q + 7'd1;
        end else begin
          state_d = APPLE;
          plot_d  = apple_on;
          if (apple_on) begin
            x_d      = apple_x_q;
            y_d      = apple_y_q;
            colour_d = C_APPLE;
          end else begin
            colour_d = colour_q;
          end
        end
      end

      // Index 0 is already on seg_idx here, so segment 0 data arrives in the first SNAKE cycle.
      APPLE: begin
        if (len_q == 8'd0) begin
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d   = SNAKE;
          seg_cnt_d = '0;
          seg_idx_d = (len_q > 8'd1) ? 7'd1 : 7'd0;
        end
      end

      SNAKE: begin
        if (seg_cnt_q == len_q) begin
          state_d   = FIN;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          seg_idx_d = '0;
        end else begin
          seg_cnt_d = seg_cnt_q + 8'd1;
          if (seg_next < len_q) begin
            seg_idx_d = seg_next[6:0];
          end
          plot_d = seg_on;
          if (seg_on) begin
            x_d      = bus.seg_x;
            y_d      = bus.seg_y;
            colour_d = (seg_cnt_q == 8'd0) ? C_HEAD : C_BODY;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      seg_idx_q <= '0;
      apple_x_q <= '0;
      apple_y_q <= '0;
      len_q     <= '0;
      seg_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      seg_idx_q <= seg_idx_d;
      apple_x_q <= apple_x_d;
      apple_y_q <= apple_y_d;
      len_q     <= len_d;
      seg_cnt_q <= seg_cnt_d;
    end
  end

  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.colour  = colour_q;
  assign bus.plot    = plot_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.seg_idx = seg_idx_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Directed frames with randomised apple/snake data, checked against a pixel-list
// model of the frame built directly from the drawing rules.
module tb_frame_draw_sequencer;
  localparam int W       = 160;
  localparam int H       = 120;
  localparam int T       = 2;
  localparam int MAX_LEN = 128;
  localparam int C_BG    = 0;
  localparam int C_WALL  = 7;
  localparam int C_APPLE = 4;
  localparam int C_HEAD  = 6;
  localparam int C_BODY  = 2;
  localparam int BUDGET  = 21000;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  frame_draw_sequencer_if fif ();
  frame_draw_sequencer dut (.clk(clk), .resetn(resetn), .bus(fif));

  logic [7:0] seg_tab_x [MAX_LEN];
  logic [6:0] seg_tab_y [MAX_LEN];

  // Snake datapath stand-in: registered read, data valid one cycle after seg_idx.
  always @(posedge clk) begin
    fif.seg_x <= seg_tab_x[fif.seg_idx];
    fif.seg_y <= seg_tab_y[fif.seg_idx];
  end

  int compared   = 0;
  int mismatched = 0;
  int exp_q[$];
  int act_q[$];
  int exp_lat, exp_seg_max;
  int obs_lat, obs_seg_max, busy_gaps, done_busy, first_plot_n;

  function automatic int pix(input int px, input int py, input int pc);
    return (px << 10) | (py << 3) | pc;
  endfunction

  task automatic check_output(input string tag, input int obs, input int expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected pixel stream and timing of one frame, straight from the drawing order.
  function automatic void build_expected(input int ax, input int ay, input int size);
    int s;
    s = (size > MAX_LEN) ? MAX_LEN : size;
    exp_q.delete();
    for (int py = 0; py < H; py++)
      for (int px = 0; px < W; px++)
        exp_q.push_back(pix(px, py, C_BG));
    for (int r = 0; r < 2*T; r++)
      for (int px = 0; px < W; px++)
        exp_q.push_back(pix(px, (r < T) ? r : H - 2*T + r, C_WALL));
    for (int py = T; py < H - T; py++)
      for (int c = 0; c < 2*T; c++)
        exp_q.push_back(pix((c < T) ? c : W - 2*T + c, py, C_WALL));
    if (ax < W && ay < H) exp_q.push_back(pix(ax, ay, C_APPLE));
    for (int k = 0; k < s; k++)
      if (seg_tab_x[k] < W && seg_tab_y[k] < H)
        exp_q.push_back(pix(seg_tab_x[k], seg_tab_y[k], (k == 0) ? C_HEAD : C_BODY));
    exp_lat     = W*H + 2*T*W + 2*T*(H - 2*T) + 1 + s + ((s > 0) ? 1 : 0);
    exp_seg_max = (s > 0) ? s - 1 : 0;
  endfunction

  task automatic apply_stimulus(input int ax, input int ay, input int size,
                                input int ax_late, input bit hold);
    @(negedge clk);
    fif.apple_x    = 8'(ax);
    fif.apple_y    = 7'(ay);
    fif.snake_size = 8'(size);
    fif.start      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) fif.start = 1'b0;
    act_q.delete();
    obs_lat = -1; obs_seg_max = 0; busy_gaps = 0; done_busy = 0; first_plot_n = -1;
    for (int n = 1; n <= BUDGET && obs_lat < 0; n++) begin
      @(negedge clk);
      if (n == 100) begin
        fif.apple_x    = 8'(ax_late);
        fif.snake_size = 8'(size ^ 1);
      end
      if (fif.plot) begin
        act_q.push_back(pix(fif.x, fif.y, fif.colour));
        if (first_plot_n < 0) first_plot_n = n;
      end
      if (int'(fif.seg_idx) > obs_seg_max) obs_seg_max = int'(fif.seg_idx);
      if (fif.done) begin
        obs_lat   = n - 1;
        done_busy = int'(fif.busy);
      end else if (!fif.busy) begin
        busy_gaps++;
      end
    end
  endtask

  task automatic check_frame(input string name);
    int  first_bad;
    int  walls, dups, outside;
    bit  seen [W*H];
    check_output({name, " latency"}, obs_lat, exp_lat);
    check_output({name, " busy gaps"}, busy_gaps, 0);
    check_output({name, " busy at done"}, done_busy, 0);
    check_output({name, " seg_idx max"}, obs_seg_max, exp_seg_max);
    check_output({name, " first plot cycle"}, first_plot_n, 1);
    check_output({name, " plot count"}, act_q.size(), exp_q.size());
    first_bad = -1;
    for (int i = 0; i < exp_q.size() && i < act_q.size() && first_bad < 0; i++)
      if (act_q[i] !== exp_q[i]) first_bad = i;
    check_output({name, " first divergent pixel index"}, first_bad, -1);
    walls = 0; dups = 0; outside = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    foreach (act_q[i]) begin
      int px, py;
      if ((act_q[i] & 7) == C_WALL) begin
        px = act_q[i] >> 10;
        py = (act_q[i] >> 3) & 127;
        walls++;
        if (px < W && py < H) begin
          if (seen[py*W + px]) dups++;
          seen[py*W + px] = 1'b1;
        end
        if (!(px < T || px >= W - T || py < T || py >= H - T)) outside++;
      end
    end
    check_output({name, " wall plots"}, walls, W*H - (W - 2*T)*(H - 2*T));
    check_output({name, " wall duplicates"}, dups, 0);
    check_output({name, " wall plots off border"}, outside, 0);
  endtask

  initial begin
    int   ax, ay, ax_late, snake_plots;
    logic found, done_seen, busy_seen;

    fif.start = 1'b0; fif.apple_x = '0; fif.apple_y = '0; fif.snake_size = '0;
    foreach (seg_tab_x[k]) begin
      seg_tab_x[k] = 8'($urandom_range(0, W - 1));
      seg_tab_y[k] = 7'($urandom_range(0, H - 1));
    end
    repeat (3) @(negedge clk);
    check_output("reset x", fif.x, 0);
    check_output("reset y", fif.y, 0);
    check_output("reset plot", fif.plot, 0);
    check_output("reset busy", fif.busy, 0);
    check_output("reset done", fif.done, 0);
    check_output("reset seg_idx", fif.seg_idx, 0);
    resetn = 1'b1;

    // Abort a frame mid-CLEAR with an asynchronous reset.
    $display("[TB] reset during clear");
    @(negedge clk);
    fif.apple_x = 8'd10; fif.apple_y = 7'd10; fif.snake_size = 8'd4; fif.start = 1'b1;
    @(posedge clk);
    #1 fif.start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge clk);
      if (fif.plot && fif.x == 8'd37 && fif.y == 7'd5) found = 1'b1;
    end
    check_output("reached pixel 37,5", found, 1);
    resetn = 1'b0;
    #1;
    check_output("async reset x", fif.x, 0);
    check_output("async reset y", fif.y, 0);
    check_output("async reset colour", fif.colour, 0);
    check_output("async reset plot", fif.plot, 0);
    check_output("async reset busy", fif.busy, 0);
    @(negedge clk);
    resetn = 1'b1;
    done_seen = 1'b0; busy_seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      done_seen |= fif.done;
      busy_seen |= fif.busy;
    end
    check_output("no done after reset", done_seen, 0);
    check_output("no busy after reset", busy_seen, 0);

    // Three-segment snake at fixed positions.
    $display("[TB] frame with S=3");
    seg_tab_x[0] = 8'd80; seg_tab_y[0] = 7'd60;
    seg_tab_x[1] = 8'd79; seg_tab_y[1] = 7'd60;
    seg_tab_x[2] = 8'd78; seg_tab_y[2] = 7'd60;
    build_expected(50, 60, 3);
    apply_stimulus(50, 60, 3, 51, 1'b0);
    check_frame("S3");
    check_output("S3 done cycle", obs_lat, 20309);
    check_output("S3 first pixel", (act_q.size() > 0) ? act_q[0] : -1, pix(0, 0, C_BG));
    check_output("S3 head pixel", (act_q.size() >= 3) ? act_q[act_q.size() - 3] : -1,
                 pix(80, 60, C_HEAD));

    // Oversized snake is clamped; one segment sits off-screen.
    $display("[TB] frame with snake_size=200");
    foreach (seg_tab_x[k]) begin
      seg_tab_x[k] = 8'($urandom_range(0, W - 1));
      seg_tab_y[k] = 7'($urandom_range(0, H - 1));
    end
    seg_tab_x[5] = 8'd200; seg_tab_y[5] = 7'd10;
    ax = $urandom_range(0, 255);
    ay = $urandom_range(0, 127);
    build_expected(ax, ay, 200);
    apply_stimulus(ax, ay, 200, (ax + 7) % 256, 1'b0);
    check_frame("S200");
    check_output("S200 seg_idx reaches 127", obs_seg_max, 127);
    snake_plots = 0;
    foreach (act_q[i])
      if ((act_q[i] & 7) == C_HEAD || (act_q[i] & 7) == C_BODY) snake_plots++;
    check_output("S200 snake plots", snake_plots, 127);

    // Empty snake with start held for the whole frame and apple_x changed mid-frame.
    $display("[TB] frame with snake_size=0 and start held");
    ax      = $urandom_range(2, W - 3);
    ay      = $urandom_range(2, H - 3);
    ax_late = (ax + 40) % W;
    build_expected(ax, ay, 0);
    apply_stimulus(ax, ay, 0, ax_late, 1'b1);
    check_frame("S0");
    check_output("S0 done cycle", obs_lat, 20305);
    check_output("S0 plot cycles", act_q.size(), 20305);
    check_output("S0 last plot is latched apple",
                 (act_q.size() > 0) ? act_q[act_q.size() - 1] : -1, pix(ax, ay, C_APPLE));
    @(negedge clk);
    check_output("start ignored in done cycle busy", fif.busy, 0);
    check_output("start ignored in done cycle plot", fif.plot, 0);
    @(negedge clk);
    check_output("restart from idle busy", fif.busy, 1);
    check_output("restart from idle plot", fif.plot, 1);
    check_output("restart from idle x", fif.x, 0);
    fif.start = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
